// File: rtl/uncache_write_buffer.sv
// ---------------------------------------------------------------------------
// uncache_write_buffer
//
// Ordered store buffer between the LSU uncached path and the uncached AXI
// port of the bus interface. Uncached stores (MMIO, uart, confreg) are queued
// and drained one at a time over the uncache_wr_* request/ready/bvalid
// handshake. Uncached loads are forwarded over uncache_rd_* only once every
// older store has received its write response, so loads and stores reach the
// device in program order.
//
// Handshakes: a request is transferred on the clock edge where both its
// request/valid and its ready are high. A request, once raised, keeps its
// payload stable until that edge. bvalid and uncache_ret_valid are one-cycle
// pulses and need no ready.
//
// Optional feature: define UNCACHE_WB_STAT_EN to add the 32-bit stall
// counters stat_ld_stall and stat_full_stall.
//
// Ports:
//   clk, reset                    clock, asynchronous active-high reset
//   st_valid/st_ready             LSU store request (addr, size, wstrb, data)
//   ld_valid/ld_ready             LSU load request (addr, size)
//   ld_ret_valid, ld_ret_data     load data return, one cycle
//   uncache_wr_req/rdy/bvalid     write request, acceptance, response
//   uncache_wr_addr/size/wstrb/data  write payload (head entry)
//   uncache_rd_req/rdy            read request and acceptance
//   uncache_rd_addr/size          read payload (passes through from LSU)
//   uncache_ret_valid/data        read data from the bus interface
//   wb_empty                      nothing buffered and both FSMs idle
//   wb_count                      occupied entries
//   stat_ld_stall, stat_full_stall  (UNCACHE_WB_STAT_EN only)
// ---------------------------------------------------------------------------
module uncache_write_buffer #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     st_valid,
    output logic                     st_ready,
    input  logic [31:0]              st_addr,
    input  logic [2:0]               st_size,
    input  logic [3:0]               st_wstrb,
    input  logic [31:0]              st_data,
    input  logic                     ld_valid,
    output logic                     ld_ready,
    input  logic [31:0]              ld_addr,
    input  logic [2:0]               ld_size,
    output logic                     ld_ret_valid,
    output logic [31:0]              ld_ret_data,
    output logic                     uncache_wr_req,
    output logic [31:0]              uncache_wr_addr,
    output logic [2:0]               uncache_wr_size,
    output logic [3:0]               uncache_wr_wstrb,
    output logic [31:0]              uncache_wr_data,
    input  logic                     uncache_wr_rdy,
    input  logic                     uncache_wr_bvalid,
    output logic                     uncache_rd_req,
    output logic [31:0]              uncache_rd_addr,
    output logic [2:0]               uncache_rd_size,
    input  logic                     uncache_rd_rdy,
    input  logic                     uncache_ret_valid,
    input  logic [31:0]              uncache_ret_data,
    output logic                     wb_empty,
    output logic [$clog2(DEPTH):0]   wb_count
`ifdef UNCACHE_WB_STAT_EN
    ,
    output logic [31:0]              stat_ld_stall,
    output logic [31:0]              stat_full_stall
`endif
);

    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic [31:0] addr;
        logic [2:0]  size;
        logic [3:0]  wstrb;
        logic [31:0] data;
    } entry_t;

    typedef enum logic {
        D_IDLE,
        D_RESP
    } drain_state_e;

    typedef enum logic {
        R_IDLE,
        R_WAIT
    } rd_state_e;

    // Entry storage carries no reset: contents are only meaningful between
    // the pointers, which are reset.
    entry_t        mem_q [DEPTH];
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    drain_state_e  drain_state_q, drain_state_d;
    rd_state_e     rd_state_q, rd_state_d;

    logic   full;
    logic   empty;
    logic   push;
    logic   pop;
    entry_t head;

    // Full/empty come from registered pointers only, so st_ready never
    // depends combinationally on bvalid; a pop in a full cycle cannot make
    // room for a push until the following cycle.
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign push  = st_valid && !full;
    assign pop   = (drain_state_q == D_RESP) && uncache_wr_bvalid;
    assign head  = mem_q[rd_ptr_q[AW-1:0]];

    assign st_ready = !full;
    assign wb_count = wr_ptr_q - rd_ptr_q;
    assign wb_empty = empty && (drain_state_q == D_IDLE) && (rd_state_q == R_IDLE);

    // Write payload always shows the head; pushes only touch the tail, so the
    // fields stay stable while a request waits for uncache_wr_rdy.
    assign uncache_wr_addr  = head.addr;
    assign uncache_wr_size  = head.size;
    assign uncache_wr_wstrb = head.wstrb;
    assign uncache_wr_data  = head.data;

    assign uncache_rd_addr = ld_addr;
    assign uncache_rd_size = ld_size;
    assign ld_ret_data     = uncache_ret_data;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    // Drain FSM: one write outstanding at a time. Draining waits while a load
    // is in flight so the store cannot overtake it at the device.
    always_comb begin
        drain_state_d  = drain_state_q;
        uncache_wr_req = 1'b0;
        case (drain_state_q)
            D_IDLE: begin
                uncache_wr_req = !empty && (rd_state_q == R_IDLE);
                if (uncache_wr_req && uncache_wr_rdy) begin
                    drain_state_d = D_RESP;
                end
            end
            D_RESP: begin
                if (uncache_wr_bvalid) begin
                    drain_state_d = D_IDLE;
                end
            end
            default: drain_state_d = D_IDLE;
        endcase
    end

    // Read FSM: a load issues only with nothing buffered and no write in
    // flight. A store presented in the same cycle is older, so it also blocks.
    always_comb begin
        rd_state_d     = rd_state_q;
        uncache_rd_req = 1'b0;
        ld_ready       = 1'b0;
        ld_ret_valid   = 1'b0;
        case (rd_state_q)
            R_IDLE: begin
                uncache_rd_req = ld_valid && empty && (drain_state_q == D_IDLE) && !st_valid;
                ld_ready       = uncache_rd_req && uncache_rd_rdy;
                if (ld_ready) begin
                    rd_state_d = R_WAIT;
                end
            end
            R_WAIT: begin
                ld_ret_valid = uncache_ret_valid;
                if (uncache_ret_valid) begin
                    rd_state_d = R_IDLE;
                end
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            drain_state_q <= D_IDLE;
            rd_state_q    <= R_IDLE;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            drain_state_q <= drain_state_d;
            rd_state_q    <= rd_state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= '{addr: st_addr, size: st_size,
                                        wstrb: st_wstrb, data: st_data};
        end
    end

`ifdef UNCACHE_WB_STAT_EN
    logic [31:0] stat_ld_stall_q, stat_ld_stall_d;
    logic [31:0] stat_full_stall_q, stat_full_stall_d;

    always_comb begin
        stat_ld_stall_d   = stat_ld_stall_q;
        stat_full_stall_d = stat_full_stall_q;
        if ((rd_state_q == R_IDLE) && ld_valid && !uncache_rd_req) begin
            stat_ld_stall_d = stat_ld_stall_q + 32'd1;
        end
        if (st_valid && full) begin
            stat_full_stall_d = stat_full_stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_ld_stall_q   <= '0;
            stat_full_stall_q <= '0;
        end else begin
            stat_ld_stall_q   <= stat_ld_stall_d;
            stat_full_stall_q <= stat_full_stall_d;
        end
    end

    assign stat_ld_stall   = stat_ld_stall_q;
    assign stat_full_stall = stat_full_stall_q;
`endif

endmodule

// File: doc/uncache_write_buffer.md
# uncache_write_buffer

Ordered store buffer between the LSU's uncached path and the uncached AXI port of the CPU bus interface. It queues uncached stores (MMIO, uart, confreg), drains them one at a time over the `uncache_wr_*` request/ready/bvalid handshake, and forwards uncached loads over `uncache_rd_*`. A load is issued only after every older store has received its write response, so loads and stores reach the device in program order.

## Interface
- `DEPTH`, 4: store entries; power of two, ≥2.
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-high.
- `st_valid` in 1: LSU uncached store request.
- `st_ready` out 1: store accepted on `st_valid && st_ready`.
- `st_addr` in 32, `st_size` in 3, `st_wstrb` in 4, `st_data` in 32: store payload.
- `ld_valid` in 1: LSU uncached load request.
- `ld_ready` out 1: load address accepted.
- `ld_addr` in 32, `ld_size` in 3: load payload.
- `ld_ret_valid` out 1, `ld_ret_data` out 32: load data return, one cycle.
- `uncache_wr_req` out 1, `uncache_wr_addr` out 32, `uncache_wr_size` out 3, `uncache_wr_wstrb` out 4, `uncache_wr_data` out 32: write request to the bus interface.
- `uncache_wr_rdy` in 1: write address accepted.
- `uncache_wr_bvalid` in 1: write response, one cycle.
- `uncache_rd_req` out 1, `uncache_rd_addr` out 32, `uncache_rd_size` out 3: read request.
- `uncache_rd_rdy` in 1: read address accepted.
- `uncache_ret_valid` in 1, `uncache_ret_data` in 32: read data.
- `wb_empty` out 1: FIFO empty, drain FSM in D_IDLE, read FSM in R_IDLE.
- `wb_count` out $clog2(DEPTH)+1: occupied entries.

## Operation
- FIFO: DEPTH entries of {addr, size, wstrb, data}. Read and write pointers are $clog2(DEPTH)+1 bits wide. Full when the pointer MSBs differ and the low bits are equal; empty when the pointers are equal. Pointers wrap naturally.
- `st_ready = !full`. This is registered state only; there is no combinational path from `bvalid`. When full, a same-cycle pop does not admit a push.
- Simultaneous push and pop are allowed. In that case the count is unchanged.
- Drain FSM:
  - D_IDLE: `uncache_wr_req = !empty && rd_state==R_IDLE`. The `uncache_wr_*` fields always equal the head entry.
  - D_IDLE → D_RESP on `uncache_wr_req && uncache_wr_rdy`.
  - D_RESP: `uncache_wr_req = 0`. On `uncache_wr_bvalid`, pop the head and return to D_IDLE.
  - At most one write is outstanding.
- Once asserted, `uncache_wr_req` and its fields hold stable until `uncache_wr_rdy`. Pushes only modify the tail entry.
- Read FSM:
  - R_IDLE: `uncache_rd_req = ld_valid && empty && drain==D_IDLE && !st_valid`.
  - A store presented in the same cycle as a load is older than the load, so the load waits.
  - `uncache_rd_addr/size` pass through from `ld_addr/ld_size`.
  - `ld_ready = uncache_rd_req && uncache_rd_rdy`; on this, go to R_WAIT.
  - R_WAIT: `ld_ret_valid = uncache_ret_valid` and `ld_ret_data = uncache_ret_data`, both combinational. On `uncache_ret_valid`, go to R_IDLE.
  - While in R_WAIT, stores are still accepted, but draining is held off until R_IDLE.
- Reset, including mid-transaction:
  - Clears pointers and both FSMs; buffered stores are discarded.
  - The bus interface shares `reset`, so no orphan response is expected.
  - Reset outputs: `st_ready=1`, `ld_ready=0`, `ld_ret_valid=0`, `uncache_wr_req=0`, `uncache_rd_req=0`, `wb_empty=1`, `wb_count=0`, stat counters 0.
  - Payload outputs are don't-care while their req is low.

## Timing
- Store accepted at edge N → `uncache_wr_req` high in cycle N+1, when the read FSM is idle.
- `uncache_wr_rdy` at edge M → D_RESP from M+1.
- `bvalid` at edge K → head popped at K; the next `uncache_wr_req` is in cycle K+1 if entries remain.
- Load behind stores: `uncache_rd_req` rises in the cycle after the last pop.
- With the buffer empty, `uncache_rd_req` is asserted in the same cycle as `ld_valid`.
- `ld_ret_valid` has zero added latency relative to `uncache_ret_valid`.
- Per-store throughput: 1 cycle of request plus the bus round-trip; no bubbles beyond one cycle per store.

## Configuration
- Macro `UNCACHE_WB_STAT_EN`, when defined, adds two output ports, each 32 bits wide and reset to 0, incrementing by 1 and wrapping at 2^32:
  - `stat_ld_stall`: counts cycles where the read FSM is in R_IDLE, `ld_valid` is high and `uncache_rd_req` is low.
  - `stat_full_stall`: counts cycles where `st_valid && full`.
- Undefined: both ports and counters are absent; all other behaviour is identical.

## Test plan
- Single store, addr 0xBFAF_F000, data 0x0000_00A5, wstrb 4'b0001, `wr_rdy` at cycle +1 and `bvalid` at cycle +3 → one `uncache_wr_req` with exact fields; `wb_count` goes 1→0 after `bvalid`; `wb_empty=1` afterwards.
- Push 5 stores with DEPTH=4 and `wr_rdy` held low → `st_ready=0` after the 4th store; the 5th store is held. Release with `wr_rdy`/`bvalid` → all 5 drained in push order with correct wstrb/size.
- Two stores queued, then a load to 0xBFAF_F010 → `uncache_rd_req` stays low until the 2nd `bvalid`, then rises the next cycle. `ld_ret_data` equals the returned 0x1234_5678 in the same cycle as `uncache_ret_valid`.
- `st_valid` and `ld_valid` in the same cycle with the buffer empty → store accepted, load blocked; write completes, then the read issues.
- Assert `reset` asynchronously while in D_RESP with 3 entries → all outputs at reset values immediately; no request is reissued after reset.
- With `UNCACHE_WB_STAT_EN`: a load blocked 7 cycles → `stat_ld_stall=7`; st_valid held against a full buffer for 3 cycles → `stat_full_stall=3`.
